// File: rtl/fetch_sequencer.sv
// fetch_sequencer
//   Owns the fetch PC for the LEGv8 core, drives the combinational IMEM
//   address, and buffers fetched words in a small FIFO. Decode reads the FIFO
//   through a valid/ready handshake. Branch redirects flush the FIFO and reload
//   the PC. A sticky fault is raised on misaligned or out-of-range fetches.
//
// Ports
//   clk_i          clock, rising edge
//   rst_i          asynchronous active-high reset
//   enable_i       run request; 0 stops new fetches, queue contents kept
//   redirect_i     branch taken / jump: load redirect_pc_i, flush queue
//   redirect_pc_i  new fetch byte address
//   imem_address_o IMEM address (copy of the fetch PC)
//   imem_data_i    IMEM read data for imem_address_o, same cycle
//   inst_valid_o   queue head valid
//   inst_ready_i   decode accepts the head
//   inst_o         queue head instruction
//   inst_pc_o      byte address of the queue head
//   fetch_pc_o     next address to fetch
//   fault_o        sticky fetch fault
//   count_o        occupied queue entries
module fetch_sequencer #(
   parameter int unsigned  QDEPTH     = 2,
   parameter logic [63:0]  RESET_PC   = 64'h0,
   parameter logic [63:0]  IMEM_LIMIT = 64'h038,
   localparam int unsigned CNT_W      = $clog2(QDEPTH + 1),
   localparam int unsigned PTR_W      = $clog2(QDEPTH)
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             enable_i,
   input  logic             redirect_i,
   input  logic [63:0]      redirect_pc_i,
   output logic [63:0]      imem_address_o,
   input  logic [31:0]      imem_data_i,
   output logic             inst_valid_o,
   input  logic             inst_ready_i,
   output logic [31:0]      inst_o,
   output logic [63:0]      inst_pc_o,
   output logic [63:0]      fetch_pc_o,
   output logic             fault_o,
   output logic [CNT_W-1:0] count_o
);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_FETCH = 2'd1;
   localparam logic [1:0] ST_HALT  = 2'd2;

   logic [1:0]       state_q, state_d;
   logic [63:0]      fetch_pc_q, fetch_pc_d;
   logic             fault_q, fault_d;
   logic [CNT_W-1:0] count_q;
   logic [PTR_W-1:0] head_q, tail_q;
   logic [63:0]      pc_mem_q   [QDEPTH];
   logic [31:0]      inst_mem_q [QDEPTH];

   logic fetch_legal, redirect_aligned, redirect_legal;
   logic push, pop, flush;

   assign fetch_legal      = (fetch_pc_q[1:0] == 2'b00) && (fetch_pc_q < IMEM_LIMIT);
   assign redirect_aligned = (redirect_pc_i[1:0] == 2'b00);
   assign redirect_legal   = redirect_aligned && (redirect_pc_i < IMEM_LIMIT);

   assign pop   = inst_valid_o && inst_ready_i;
   assign flush = redirect_i;
   // A full queue can still accept a push when the head leaves in the same cycle.
   assign push  = (state_q == ST_FETCH) && enable_i && !redirect_i && fetch_legal &&
                  ((count_q < CNT_W'(QDEPTH)) || pop);

   always_comb begin
      state_d    = state_q;
      fetch_pc_d = fetch_pc_q;
      fault_d    = fault_q;
      if (redirect_i) begin
         fetch_pc_d = redirect_pc_i;
         if (!redirect_aligned) begin
            fault_d = 1'b1;
            state_d = ST_HALT;
         end else if (state_q == ST_HALT) begin
            // Only a fully legal target releases the fault; otherwise stay halted.
            if (redirect_legal) begin
               fault_d = 1'b0;
               state_d = ST_FETCH;
            end
         end else if ((state_q == ST_FETCH) && !enable_i) begin
            state_d = ST_IDLE;
         end
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (enable_i) state_d = ST_FETCH;
            end
            ST_FETCH: begin
               if (!enable_i) begin
                  state_d = ST_IDLE;
               end else if (!fetch_legal) begin
                  fault_d = 1'b1;
                  state_d = ST_HALT;
               end else if (push) begin
                  fetch_pc_d = fetch_pc_q + 64'd4;
               end
            end
            ST_HALT: ;
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q    <= ST_IDLE;
         fetch_pc_q <= RESET_PC;
         fault_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         fetch_pc_q <= fetch_pc_d;
         fault_q    <= fault_d;
      end
   end

   // Queue storage and pointers. Pointer width is log2(QDEPTH), so natural
   // binary wrap gives the modulo-QDEPTH behaviour.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         for (int i = 0; i < QDEPTH; i++) begin
            pc_mem_q[i]   <= '0;
            inst_mem_q[i] <= '0;
         end
      end else if (flush) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         if (push) begin
            pc_mem_q[tail_q]   <= fetch_pc_q;
            inst_mem_q[tail_q] <= imem_data_i;
            tail_q             <= tail_q + PTR_W'(1);
         end
         if (pop) begin
            head_q <= head_q + PTR_W'(1);
         end
         case ({push, pop})
            2'b10:   count_q <= count_q + CNT_W'(1);
            2'b01:   count_q <= count_q - CNT_W'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   assign imem_address_o = fetch_pc_q;
   assign fetch_pc_o     = fetch_pc_q;
   assign fault_o        = fault_q;
   assign count_o        = count_q;
   assign inst_valid_o   = (count_q != '0);
   assign inst_o         = inst_mem_q[head_q];
   assign inst_pc_o      = pc_mem_q[head_q];

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer
//   Directed bench for fetch_sequencer. Stimulus pushes the expected
//   {InstPC, Inst} of every instruction decode should accept into a queue; a
//   monitor pops and compares on each accepted head. Register state (Count,
//   FetchPC, Fault, ImemAddress) is checked directly at scenario points.
module tb_fetch_sequencer;

   logic        clk = 1'b0;
   logic        rst;
   logic        enable;
   logic        redirect;
   logic [63:0] redirect_pc;
   logic [63:0] imem_address;
   logic [31:0] imem_data;
   logic        inst_valid;
   logic        ready;
   logic [31:0] inst;
   logic [63:0] inst_pc;
   logic [63:0] fetch_pc;
   logic        fault;
   logic [1:0]  count;

   int total = 0;
   int bad   = 0;
   logic [95:0] exp_q[$];
   logic [95:0] mon_e;

   fetch_sequencer #(
      .QDEPTH     (2),
      .RESET_PC   (64'h0),
      .IMEM_LIMIT (64'h038)
   ) dut (
      .clk_i          (clk),
      .rst_i          (rst),
      .enable_i       (enable),
      .redirect_i     (redirect),
      .redirect_pc_i  (redirect_pc),
      .imem_address_o (imem_address),
      .imem_data_i    (imem_data),
      .inst_valid_o   (inst_valid),
      .inst_ready_i   (ready),
      .inst_o         (inst),
      .inst_pc_o      (inst_pc),
      .fetch_pc_o     (fetch_pc),
      .fault_o        (fault),
      .count_o        (count)
   );

   always #5 clk = ~clk;

   // Combinational IMEM contents.
   function automatic logic [31:0] rom_word(input logic [63:0] a);
      if (a >= 64'h038) return 32'hDEAD_BEEF;
      case (a[5:2])
         4'd0:    return 32'hAA1F_03F4;
         4'd1:    return 32'hF840_0289;
         default: return {16'hC0DE, 10'h000, a[5:0]};
      endcase
   endfunction

   always_comb imem_data = rom_word(imem_address);

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, req);
      end
   endtask

   task automatic expect_inst(input logic [63:0] pc, input logic [31:0] w);
      exp_q.push_back({pc, w});
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst      = 1'b1;
      enable   = 1'b0;
      redirect = 1'b0;
      step();
      step();
      chk("rst_valid", inst_valid, 0);
      chk("rst_count", count, 0);
      chk("rst_fetch_pc", fetch_pc, 64'h0);
      chk("rst_fault", fault, 0);
      chk("rst_inst", inst, 0);
      chk("rst_inst_pc", inst_pc, 0);
      rst = 1'b0;
   endtask

   // Monitor: one line per accepted instruction, compared with the scoreboard.
   initial begin
      forever begin
         @(negedge clk);
         if (!rst && inst_valid && ready) begin
            $display("accept pc=%h inst=%h", inst_pc, inst);
            if (exp_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_accept: got pc %h, want no instruction", inst_pc);
            end else begin
               mon_e = exp_q.pop_front();
               chk("accept_pc", inst_pc, mon_e[95:32]);
               chk("accept_inst", {32'h0, inst}, {32'h0, mon_e[31:0]});
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, want completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst         = 1'b1;
      enable      = 1'b0;
      redirect    = 1'b0;
      redirect_pc = 64'h0;
      ready       = 1'b1;

      // 1: first fetch latency and streaming
      do_reset();
      enable = 1'b1;
      expect_inst(64'h000, 32'hAA1F_03F4);
      expect_inst(64'h004, 32'hF840_0289);
      step();
      chk("t1_c1_valid", inst_valid, 0);
      step();
      chk("t1_c2_valid", inst_valid, 1);
      chk("t1_c2_inst", inst, 32'hAA1F_03F4);
      chk("t1_c2_pc", inst_pc, 64'h000);
      step();
      chk("t1_c3_inst", inst, 32'hF840_0289);
      chk("t1_c3_pc", inst_pc, 64'h004);
      enable = 1'b0;
      step();
      chk("t1_count", count, 0);
      chk("t1_fetch_pc", fetch_pc, 64'h008);

      // 2: backpressure fills the queue, then drains in order
      ready = 1'b0;
      do_reset();
      enable = 1'b1;
      repeat (6) step();
      chk("t2_full_count", count, 2);
      chk("t2_full_fetch_pc", fetch_pc, 64'h008);
      chk("t2_full_head", inst_pc, 64'h000);
      expect_inst(64'h000, 32'hAA1F_03F4);
      expect_inst(64'h004, 32'hF840_0289);
      expect_inst(64'h008, 32'hC0DE_0008);
      ready = 1'b1;
      step();
      chk("t2_pushpop_full_count", count, 2);
      chk("t2_pushpop_head", inst_pc, 64'h004);
      enable = 1'b0;
      step();
      chk("t2_count_one", count, 1);
      step();
      chk("t2_drained", count, 0);
      chk("t2_fetch_pc", fetch_pc, 64'h00C);

      // 3: redirect with a same-cycle pop flushes 0x028
      ready       = 1'b0;
      redirect    = 1'b1;
      redirect_pc = 64'h024;
      step();
      chk("t3_idle_redirect_pc", fetch_pc, 64'h024);
      chk("t3_idle_count", count, 0);
      redirect = 1'b0;
      enable   = 1'b1;
      repeat (4) step();
      chk("t3_full_count", count, 2);
      chk("t3_full_head", inst_pc, 64'h024);
      chk("t3_full_fetch_pc", fetch_pc, 64'h02C);
      expect_inst(64'h024, 32'hC0DE_0024);
      expect_inst(64'h020, 32'hC0DE_0020);
      redirect    = 1'b1;
      redirect_pc = 64'h020;
      ready       = 1'b1;
      step();
      chk("t3_flush_count", count, 0);
      chk("t3_flush_fetch_pc", fetch_pc, 64'h020);
      chk("t3_flush_valid", inst_valid, 0);
      redirect = 1'b0;
      step();
      chk("t3_new_head", inst_pc, 64'h020);
      enable = 1'b0;
      step();
      chk("t3_end_count", count, 0);
      chk("t3_end_fetch_pc", fetch_pc, 64'h024);

      // 4: run off the end of IMEM, drain, recover
      ready       = 1'b0;
      redirect    = 1'b1;
      redirect_pc = 64'h030;
      step();
      redirect = 1'b0;
      enable   = 1'b1;
      repeat (4) step();
      chk("t4_fault", fault, 1);
      chk("t4_fault_count", count, 2);
      chk("t4_fault_fetch_pc", fetch_pc, 64'h038);
      chk("t4_fault_head", inst_pc, 64'h030);
      expect_inst(64'h030, 32'hC0DE_0030);
      expect_inst(64'h034, 32'hC0DE_0034);
      ready = 1'b1;
      repeat (2) step();
      chk("t4_drained", count, 0);
      chk("t4_still_fault", fault, 1);
      step();
      chk("t4_halt_no_push", inst_valid, 0);
      expect_inst(64'h000, 32'hAA1F_03F4);
      redirect    = 1'b1;
      redirect_pc = 64'h000;
      step();
      chk("t4_fault_cleared", fault, 0);
      chk("t4_resume_pc", fetch_pc, 64'h000);
      redirect = 1'b0;
      step();
      chk("t4_resume_head", inst_pc, 64'h000);
      chk("t4_resume_valid", inst_valid, 1);
      enable = 1'b0;
      step();
      chk("t4_end_fetch_pc", fetch_pc, 64'h004);

      // 5: misaligned redirect
      enable = 1'b1;
      repeat (2) step();
      expect_inst(64'h004, 32'hF840_0289);
      redirect    = 1'b1;
      redirect_pc = 64'h012;
      step();
      chk("t5_fault", fault, 1);
      chk("t5_count", count, 0);
      chk("t5_imem_addr", imem_address, 64'h012);
      redirect = 1'b0;
      repeat (3) step();
      chk("t5_no_push", count, 0);
      chk("t5_pc_held", fetch_pc, 64'h012);

      // 6: asynchronous reset while full
      ready       = 1'b0;
      redirect    = 1'b1;
      redirect_pc = 64'h000;
      step();
      chk("t6_recover", fault, 0);
      redirect = 1'b0;
      repeat (3) step();
      chk("t6_full_count", count, 2);
      chk("t6_full_valid", inst_valid, 1);
      @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      chk("t6_async_valid", inst_valid, 0);
      chk("t6_async_count", count, 0);
      chk("t6_async_fetch_pc", fetch_pc, 64'h0);
      chk("t6_async_imem_addr", imem_address, 64'h0);
      chk("t6_async_inst_pc", inst_pc, 0);
      step();
      rst    = 1'b0;
      enable = 1'b0;
      step();

      chk("scoreboard_empty", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
